// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/status bundle between the multicycle controller and its datapath.
// The controller is the master; the datapath (or a bench) is the slave.
interface multicycle_controller_if #(
  parameter int OPW    = 6,
  parameter int STATEW = 4
);
  logic [OPW-1:0]    opcode;
  logic              zero;
  logic              mem_ready;
  logic              mem_read;
  logic              mem_write;
  logic              i_or_d;
  logic              ir_write;
  logic              pc_write;
  logic              pc_write_cond;
  logic              branch_ne;
  logic [1:0]        pc_source;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic [1:0]        alu_op;
  logic              reg_dst;
  logic              mem_to_reg;
  logic              reg_write;
  logic              instr_done;
  logic              illegal_op;
  logic [STATEW-1:0] state;
  modport master (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           instr_done, illegal_op, state
  );
  modport slave (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM for the multicycle MIPS datapath (R, lw, sw, beq, bne).
// Define JUMP_EN to decode opcode 2 (j) through the JUMP state; otherwise opcode 2 is illegal.
module multicycle_controller (
  input logic                     clock,
  input logic                     reset,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9
  } state_t;
  state_t     r_state, w_next;
  logic [5:0] r_op;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state <= FETCH;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_op <= bus.opcode;
    end
  // All outputs are forced low while reset is held, so nothing half-finished reaches memory.
  always_comb begin
    w_next            = r_state;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.pc_source     = 2'b00;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;
    bus.state         = reset ? r_state : FETCH;
    if (reset) begin
      case (r_state)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
          w_next        = bus.mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          bus.alu_src_b = 2'b11;
          case (bus.opcode)
            6'd0:        w_next = EXECUTE;
            6'd35, 6'd43: w_next = MEM_ADDR;
            6'd4, 6'd5:  w_next = BRANCH;
`ifdef JUMP_EN
            6'd2:        w_next = JUMP;
`endif
            default: begin
              w_next         = FETCH;
              bus.illegal_op = 1'b1;
              bus.instr_done = 1'b1;
            end
          endcase
        end
        MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          w_next        = (r_op == 6'd35) ? MEM_READ : MEM_WRITE;
        end
        MEM_READ: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
          w_next       = bus.mem_ready ? MEM_WB : MEM_READ;
        end
        MEM_WB: begin
          bus.mem_to_reg = 1'b1;
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
          w_next         = FETCH;
        end
        MEM_WRITE: begin
          bus.mem_write  = 1'b1;
          bus.i_or_d     = 1'b1;
          bus.instr_done = bus.mem_ready;
          w_next         = bus.mem_ready ? FETCH : MEM_WRITE;
        end
        EXECUTE: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
          w_next        = ALU_WB;
        end
        ALU_WB: begin
          bus.reg_dst    = 1'b1;
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
          w_next         = FETCH;
        end
        BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = 2'b01;
          bus.pc_source     = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.branch_ne     = (r_op == 6'd5);
          bus.instr_done    = 1'b1;
          w_next            = FETCH;
        end
`ifdef JUMP_EN
        JUMP: begin
          bus.pc_source  = 2'b10;
          bus.pc_write   = 1'b1;
          bus.instr_done = 1'b1;
          w_next         = FETCH;
        end
`endif
        default: begin
          bus.illegal_op = 1'b1;
          w_next         = FETCH;
        end
      endcase
    end
  end
endmodule
